adder_bist_ctrl: RTL
====================

# adder_bist_ctrl

Built-in self-test controller for the team's WIDTH-bit ripple-carry adder. It drives the adder's operand and carry-in ports through all 2^(2·WIDTH+1) input combinations and samples the sum and carry-out after a programmable settle time. It compares each result against an internal golden sum and reports a mismatch count with pass/done status. It sits on the other side of the adder interface from the adder itself and replaces the simulation-only stimulus bench with synthesizable on-chip checking.

## Interface
- WIDTH, 4, adder operand width; legal range 1..8.
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a full sweep.
- a  out  WIDTH  adder operand A.
- b  out  WIDTH  adder operand B.
- c_0  out  1  adder carry-in.
- s  in  WIDTH  adder sum.
- c_out  in  1  adder carry-out.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next start or rst.
- pass  out  1  done and err_count == 0.
- err_count  out  2·WIDTH+2  number of mismatching vectors.

## Operation
- Vector index idx is a (2·WIDTH+1)-bit register: a = idx[WIDTH-1:0], b = idx[2·WIDTH-1:WIDTH], c_0 = idx[2·WIDTH]. Index 0 is swept first and increments by 1.
- Golden value is a + b + c_0, zero-extended to WIDTH+1 bits. Observed value is {c_out, s}. Any bit difference is one error.
- FSM states:
  - IDLE: start=1 -> DRIVE; clears idx, settle counter and err_count.
  - DRIVE: holds the vector for SETTLE cycles, then -> CHECK.
  - CHECK: compares once. If idx is the last index (all ones) -> DONE; otherwise idx+1 -> DRIVE.
  - DONE: start=1 -> DRIVE with the same clearing as IDLE; otherwise stays.
- start in DRIVE or CHECK is ignored.
- err_count cannot overflow: its maximum is 2^(2·WIDTH+1), which fits in 2·WIDTH+2 bits. No saturation logic is needed.
- a, b and c_0 are driven from registers only, with no combinational path from s/c_out.

## Timing
- Reset values: a=0, b=0, c_0=0, busy=0, done=0, pass=0, err_count=0, state IDLE. With ADDER_BIST_FIRST_FAIL_EN defined, also fail_valid=0 and fail_vec=0.
- rst has priority over start. rst asserted mid-sweep returns every output to its reset value at the next edge, with no partial result retained.
- Cycle 0 is the edge that samples start: busy=1, done=0, vector 0 on a/b/c_0.
- Each vector is on the bus for SETTLE+1 cycles. It is compared at the CHECK edge, and the next vector appears after that edge.
- done rises, busy falls and pass becomes valid at edge 2^(2·WIDTH+1)·(SETTLE+1) after cycle 0.
- err_count updates at the CHECK edge of the failing vector. It is stable while done=1.

## Configuration
- Macro ADDER_BIST_FIRST_FAIL_EN. When defined, two extra ports exist:
  - fail_valid  out  1
  - fail_vec  out  2·WIDTH+1
- At the first mismatch of a sweep, fail_vec latches idx and fail_valid sets. Later mismatches do not change either signal. Both clear on start and rst.
- When undefined, these ports and their registers are absent. All other behaviour is identical.

## Test plan
- Ideal adder model, WIDTH=4, SETTLE=1, start pulse -> busy high for 1024 cycles; done=1 at cycle 1024; err_count=0; pass=1.
- s[0] stuck at 0 -> err_count=256, pass=0. With the macro defined: fail_vec=1 (a=1, b=0, c_0=0) and fail_valid=1.
- c_out stuck at 0 -> err_count=256. With the macro defined: fail_vec=0x1F (a=15, b=1, c_0=0).
- SETTLE=3 with an ideal adder; assert start again at cycle 500 -> the extra start is ignored; done=1 at cycle 2048; pass=1. A start while done=1 reruns the sweep and clears err_count at the start edge.
- rst asserted while idx=100 -> next edge: a=b=c_0=0, busy=0, done=0, err_count=0. A subsequent start sweeps from vector 0.

Source files
------------

// File: rtl/adder_bist_ctrl.sv
// Built-in self-test sequencer for a WIDTH-bit ripple-carry adder: exhaustive sweep, settle, compare, count.
// Define ADDER_BIST_FIRST_FAIL_EN to add fail_valid/fail_vec capture of the first failing vector.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start after reset; all results at reset values
// S_DRIVE | current vector on a/b/c_0, settle down-counter running
// S_CHECK | compare {c_out, s} against golden, then advance or finish
// S_DONE  | sweep complete; err_count/pass held until next start

module adder_bist_ctrl #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [WIDTH-1:0]     a,
   output logic [WIDTH-1:0]     b,
   output logic                 c_0,
   input  logic [WIDTH-1:0]     s,
   input  logic                 c_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH+1:0]   err_count
`ifdef ADDER_BIST_FIRST_FAIL_EN
   ,
   output logic                 fail_valid,
   output logic [2*WIDTH:0]     fail_vec
`endif
);

   localparam int IW = 2*WIDTH + 1;
   localparam int EW = 2*WIDTH + 2;
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [EW-1:0]   err_q, err_d;
   logic [WIDTH:0]  golden;
   logic [WIDTH:0]  observed;
   logic            mismatch;
   logic            last_vec;

`ifdef ADDER_BIST_FIRST_FAIL_EN
   logic            fv_q, fv_d;
   logic [IW-1:0]   fvec_q, fvec_d;
`endif

   // Golden sum is formed from the registered index, never from the adder's outputs.
   assign golden   = {1'b0, idx_q[WIDTH-1:0]}
                   + {1'b0, idx_q[2*WIDTH-1:WIDTH]}
                   + {{WIDTH{1'b0}}, idx_q[2*WIDTH]};
   assign observed = {c_out, s};
   assign mismatch = (golden != observed);
   assign last_vec = &idx_q;

   assign a   = idx_q[WIDTH-1:0];
   assign b   = idx_q[2*WIDTH-1:WIDTH];
   assign c_0 = idx_q[2*WIDTH];
   assign err_count = err_q;

`ifdef ADDER_BIST_FIRST_FAIL_EN
   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
`ifdef ADDER_BIST_FIRST_FAIL_EN
         fv_q    <= 1'b0;
         fvec_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef ADDER_BIST_FIRST_FAIL_EN
         fv_q    <= fv_d;
         fvec_q  <= fvec_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      busy    = 1'b0;
      done    = 1'b0;
      pass    = 1'b0;
`ifdef ADDER_BIST_FIRST_FAIL_EN
      fv_d    = fv_q;
      fvec_d  = fvec_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            pass = (state_q == S_DONE) && (err_q == '0);
            if (start) begin
               state_d = S_DRIVE;
               idx_d   = '0;
               cnt_d   = SETTLE_LD;
               err_d   = '0;
`ifdef ADDER_BIST_FIRST_FAIL_EN
               fv_d    = 1'b0;
               fvec_d  = '0;
`endif
            end
         end

         S_DRIVE: begin
            busy = 1'b1;
            // SETTLE drive cycles plus the check cycle hold each vector SETTLE+1 cycles.
            if (cnt_q == 4'd0) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         S_CHECK: begin
            busy = 1'b1;
            if (mismatch) begin
               err_d = err_q + EW'(1);
`ifdef ADDER_BIST_FIRST_FAIL_EN
               if (!fv_q) begin
                  fv_d   = 1'b1;
                  fvec_d = idx_q;
               end
`endif
            end
            if (last_vec) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRIVE;
               idx_d   = idx_q + IW'(1);
               cnt_d   = SETTLE_LD;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
